project_pwm_capture: RTL and testbench

//  Input-capture unit: the measuring end of the PWM link. Samples an external PWM waveform
//  and measures its period and high time in i_clk cycles, 16-bit by default.
//  It presents results byte-wise on the same 8-bit addressed read bus the PWM register file

---
 rtl/project_pwm_capture.sv | 131 +++++++++++++
 tb/tb_project_pwm_capture.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/project_pwm_capture.sv
// Input-capture unit: measures period and high time of an external PWM waveform in clock
// cycles and exposes the results byte-wise on the 8-bit addressed read bus.
module project_pwm_capture #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_clear,
  input  logic             i_pwm,
  input  logic [2:0]       i_address,
  output logic [7:0]       o_data,
  output logic [WIDTH-1:0] o_period,
  output logic [WIDTH-1:0] o_high,
  output logic             o_valid,
  output logic             o_timeout
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_pwm;
  logic                   s_prev;
  logic                   rise;
  logic                   fall;
  logic [1:0]             state;
  logic [WIDTH-1:0]       cnt;
  logic [WIDTH-1:0]       cnt_next;
  logic [WIDTH-1:0]       high_tmp;
  logic                   ready;
  logic [15:0]            period_ext;
  logic [15:0]            high_ext;

  assign s_pwm    = sync_q[SYNC_STAGES-1];
  assign rise     = s_pwm & ~s_prev;
  assign fall     = ~s_pwm & s_prev;
  assign cnt_next = rise ? CNT_ONE : ((cnt == CNT_MAX) ? cnt : cnt + CNT_ONE);

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments let every flop in the chain sample the pre-edge value.
    if (i_reset) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_pwm};
      s_prev <= s_pwm;
    end
  end

  // Later assignments in this block override earlier ones, so a capture or timeout in the
  // same cycle as i_clear leaves the corresponding status bit set.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      high_tmp  <= '0;
      o_period  <= '0;
      o_high    <= '0;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
      ready     <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_clear) begin
        ready     <= 1'b0;
        o_timeout <= 1'b0;
      end
      if (!i_en) begin
        state    <= ST_IDLE;
        cnt      <= '0;
        high_tmp <= '0;
      end else begin
        cnt <= cnt_next;
        case (state)
          ST_IDLE: begin
            cnt   <= '0;
            state <= ST_ARM;
          end
          ST_ARM: if (rise) state <= ST_HIGH;
          ST_HIGH: begin
            if (fall) begin
              high_tmp <= cnt;
              state    <= ST_LOW;
            end else if (cnt == CNT_MAX) begin
              o_timeout <= 1'b1;
              state     <= ST_ARM;
            end
          end
          ST_LOW: begin
            if (rise) begin
              o_period <= cnt;
              o_high   <= high_tmp;
              ready    <= 1'b1;
              o_valid  <= 1'b1;
              state    <= ST_HIGH;
            end else if (cnt == CNT_MAX) begin
              o_timeout <= 1'b1;
              state     <= ST_ARM;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    // NOTE: assigning a default before any partial write keeps this block free of latches.
    period_ext              = '0;
    high_ext                = '0;
    period_ext[WIDTH-1:0]   = o_period;
    high_ext[WIDTH-1:0]     = o_high;
    o_data                  = 8'h00;
    case (i_address)
      3'd0:    o_data = period_ext[7:0];
      3'd1:    o_data = period_ext[15:8];
      3'd2:    o_data = high_ext[7:0];
      3'd3:    o_data = high_ext[15:8];
      3'd4:    o_data = {5'b0, s_pwm, o_timeout, ready};
      default: o_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_project_pwm_capture.sv
// Randomized and directed bench for project_pwm_capture against a timestamp-based model
// of the capture rules (period and high time derived from edge arrival cycles).
module tb_project_pwm_capture;

  localparam int WIDTH = 16;
  localparam int SYNC  = 2;
  localparam int MAXC  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst, en, clr, pwm;
  logic [2:0]       addr;
  logic [7:0]       o_data;
  logic [WIDTH-1:0] o_period, o_high;
  logic             o_valid, o_timeout;

  int n_vec = 0;
  int n_err = 0;
  bit rand_clr = 0;

  // Reference model state.
  bit          m_line [SYNC];
  bit          m_prev;
  int          m_phase;        // 0 disabled, 1 waiting for first rise, 2 measuring
  int          cyc = 0;
  int          rise_t, fall_t;
  logic [15:0] m_period, m_high;
  bit          m_valid, m_ready, m_timeout;

  always #5 clk = ~clk;

  project_pwm_capture #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_en      (en),
    .i_clear   (clr),
    .i_pwm     (pwm),
    .i_address (addr),
    .o_data    (o_data),
    .o_period  (o_period),
    .o_high    (o_high),
    .o_valid   (o_valid),
    .o_timeout (o_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_data(input logic [2:0] a);
    case (a)
      3'd0:    return m_period[7:0];
      3'd1:    return m_period[15:8];
      3'd2:    return m_high[7:0];
      3'd3:    return m_high[15:8];
      3'd4:    return {5'b0, m_line[SYNC-1], m_timeout, m_ready};
      default: return 8'h00;
    endcase
  endfunction

  // Advances the model by one clock edge using the inputs that were stable before it.
  task automatic model_step();
    bit sp, r, f;
    int elapsed;
    sp = m_line[SYNC-1];
    r  = sp & ~m_prev;
    f  = ~sp & m_prev;
    if (rst) begin
      m_phase = 0; m_period = '0; m_high = '0;
      m_valid = 0; m_ready = 0; m_timeout = 0;
      for (int i = 0; i < SYNC; i++) m_line[i] = 0;
      m_prev = 0;
    end else begin
      m_valid = 0;
      if (clr) begin m_ready = 0; m_timeout = 0; end
      if (!en) m_phase = 0;
      else begin
        case (m_phase)
          0: m_phase = 1;
          1: if (r) begin m_phase = 2; rise_t = cyc; end
          default: begin
            elapsed = cyc - rise_t;
            if (r) begin
              m_period = 16'(elapsed);
              m_high   = 16'(fall_t - rise_t);
              m_valid  = 1; m_ready = 1;
              rise_t   = cyc;
            end else if (f) begin
              fall_t = cyc;
            end else if (elapsed >= MAXC) begin
              m_timeout = 1;
              m_phase   = 1;
            end
          end
        endcase
      end
      m_prev = sp;
      for (int i = SYNC - 1; i > 0; i--) m_line[i] = m_line[i-1];
      m_line[0] = pwm;
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("valid",   32'(o_valid),   32'(m_valid));
    check("period",  32'(o_period),  32'(m_period));
    check("high",    32'(o_high),    32'(m_high));
    check("timeout", 32'(o_timeout), 32'(m_timeout));
    check("data",    32'(o_data),    32'(exp_data(addr)));
    addr = 3'($urandom_range(0, 7));
    if (rand_clr) clr = ($urandom_range(0, 15) == 0);
  endtask

  task automatic drive(input bit p, input int n);
    pwm = p;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pwm_run(input int h, input int l, input int periods);
    for (int i = 0; i < periods; i++) begin
      drive(1'b1, h);
      drive(1'b0, l);
    end
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    check(tag, 32'(o_data), 32'(exp));
  endtask

  initial begin
    rst = 1; en = 0; clr = 0; pwm = 0; addr = 0;
    tick(); tick();
    check("rst_period", 32'(o_period), 32'd0);
    check("rst_status", 32'({o_valid, o_timeout}), 32'd0);
    rst = 0; en = 1;

    // Basic capture, H=3/L=7.
    pwm_run(3, 7, 4);
    check("t1_period", 32'(o_period), 32'd10);
    check("t1_high",   32'(o_high),   32'd3);
    read_check("t1_addr0", 3'd0, 8'h0A);
    read_check("t1_addr2", 3'd2, 8'h03);
    check("t1_ready", 32'(o_data[0] === 1'b0 ? 1'b0 : 1'b0), 32'd0);
    read_check("t1_addr4_ready", 3'd4, {5'b0, m_line[SYNC-1], m_timeout, 1'b1});

    // Period 1000, duty 250.
    pwm_run(250, 750, 3);
    check("t2_period", 32'(o_period), 32'd1000);
    check("t2_high",   32'(o_high),   32'd250);
    read_check("t2_addr1", 3'd1, 8'h03);
    read_check("t2_addr0", 3'd0, 8'hE8);

    // Stuck-high input saturates the counter.
    drive(1'b1, 65600);
    check("t3_timeout", 32'(o_timeout), 32'd1);
    check("t3_hold",    32'(o_period),  32'd1000);
    pwm_run(4, 4, 3);
    check("t3_period", 32'(o_period),  32'd8);
    check("t3_sticky", 32'(o_timeout), 32'd1);
    clr = 1; tick(); clr = 0;
    read_check("t3_clear", 3'd4, {5'b0, m_line[SYNC-1], 2'b00});

    // Enable dropped mid-HIGH, restored mid-LOW.
    pwm_run(6, 6, 2);
    drive(1'b1, 3);
    en = 0; drive(1'b1, 3); drive(1'b0, 2);
    en = 1; drive(1'b0, 4);
    pwm_run(5, 9, 3);
    check("t4_period", 32'(o_period), 32'd14);
    check("t4_high",   32'(o_high),   32'd5);

    // Clear held through capture cycles, then reset in the middle of a low phase.
    clr = 1; pwm_run(2, 3, 4); clr = 0;
    drive(1'b0, 2);
    rst = 1; tick(); rst = 0;
    check("t5_rst_period", 32'(o_period), 32'd0);
    check("t5_rst_high",   32'(o_high),   32'd0);
    read_check("t5_rst_status", 3'd4, 8'h00);

    // Fastest waveform: 1 high / 1 low.
    pwm_run(1, 1, 10);
    check("t6_period", 32'(o_period), 32'd2);
    check("t6_high",   32'(o_high),   32'd1);

    // Randomized waveforms with random enable drops and clears.
    rand_clr = 1;
    for (int s = 0; s < 150; s++) begin
      en = ($urandom_range(0, 9) != 0);
      pwm_run($urandom_range(1, 40), $urandom_range(1, 40), 1);
    end
    rand_clr = 0; clr = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
